// File: rtl/tlp_frag_scheduler_if.sv
// Bundles the request, grant and beat-framing signals that connect the TLP buffers,
// the fragmentation scheduler and the DLL-side beat framer.
interface tlp_frag_scheduler_if #(
  parameter int NUM_REQ = 3,
  parameter int LEN_W   = 10,
  parameter int BEAT_DW = 8
);
  localparam int LAST_W = $clog2(BEAT_DW);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic                     halt;
  logic                     throttle;
  logic [NUM_REQ-1:0]       req_grant;
  logic                     frag_start;
  logic [LEN_W-1:0]         frag_len;
  logic                     beat_valid;
  logic                     sop;
  logic                     eop;
  logic [LAST_W-1:0]        last_dw;
  logic                     busy;

  modport master (
    input  req_valid, req_len, halt, throttle,
    output req_grant, frag_start, frag_len, beat_valid, sop, eop, last_dw, busy
  );

  modport slave (
    output req_valid, req_len, halt, throttle,
    input  req_grant, frag_start, frag_len, beat_valid, sop, eop, last_dw, busy
  );
endinterface

// File: rtl/tlp_frag_scheduler.sv
// Round-robin owner of the TX fragmentation engine: grants one source for a whole TLP
// and frames it into BEAT_DW-wide beats with sop/eop/last_dw, stalling on DLL halt/throttle.
module tlp_frag_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int LEN_W   = 10,
  parameter int BEAT_DW = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  tlp_frag_scheduler_if.master  bus
);
  localparam int LOG_B = $clog2(BEAT_DW);
  localparam int CNT_W = LEN_W - LOG_B;
  localparam int PTR_W = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   idx_q, idx_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;

  logic [LEN_W-1:0]   len_arr [NUM_REQ];
  logic [LEN_W-1:0]   len_m1;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand_idx;
  logic               win_found;
  logic               advance;
  logic               last_beat;
  int                 cand;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      len_arr[i] = bus.req_len[i*LEN_W +: LEN_W];
    end
  end

  // Search from ptr+1 upward so the most recently served source has lowest priority.
  always_comb begin
    cand      = 0;
    cand_idx  = '0;
    win_idx   = ptr_q;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(ptr_q) + k) % NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!win_found && bus.req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // L-1 in LEN_W bits wraps 0 (1024 DW) to 1023, so its upper bits give ceil(L/BEAT_DW)-1
  // and its lower bits give the valid-DW index of the final beat.
  assign len_m1    = len_q - LEN_W'(1);
  assign advance   = (state_q == S_XFER) && !bus.halt && !bus.throttle;
  assign last_beat = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_LOAD;
          grant_d = NUM_REQ'(1) << win_idx;
          idx_d   = win_idx;
          len_d   = len_arr[win_idx];
        end
      end
      S_LOAD: begin
        cnt_d   = len_m1[LEN_W-1:LOG_B];
        first_d = 1'b1;
        state_d = S_XFER;
      end
      S_XFER: begin
        if (advance) begin
          first_d = 1'b0;
          if (last_beat) begin
            state_d = S_IDLE;
            grant_d = '0;
            ptr_d   = idx_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      len_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign bus.req_grant  = grant_q;
  assign bus.frag_start = (state_q == S_LOAD);
  assign bus.frag_len   = len_q;
  assign bus.beat_valid = advance;
  assign bus.sop        = advance && first_q;
  assign bus.eop        = advance && last_beat;
  assign bus.last_dw    = (state_q == S_XFER && last_beat) ? len_m1[LOG_B-1:0] : '1;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_tlp_frag_scheduler.sv
// Self-checking bench for tlp_frag_scheduler: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_tlp_frag_scheduler;
  localparam int NUM_REQ = 3;
  localparam int LEN_W   = 10;
  localparam int BEAT_DW = 8;
  localparam int MAX_DW  = 1 << LEN_W;

  logic clk = 1'b0;
  logic arst;

  int vectors    = 0;
  int miscompares = 0;

  // reference model state: which source owns the engine and how many beats remain
  int               m_ptr, m_win, m_len, m_beats_left, m_beat_no;
  bit               m_load;
  logic [LEN_W-1:0] m_flen;

  int               beat_count, eop_count;
  logic [NUM_REQ-1:0] grant_log[$];

  always #5 clk = ~clk;

  tlp_frag_scheduler_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .BEAT_DW(BEAT_DW)) bus ();

  tlp_frag_scheduler #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .BEAT_DW(BEAT_DW)) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_ptr        = NUM_REQ - 1;
    m_win        = 0;
    m_len        = 0;
    m_beats_left = 0;
    m_beat_no    = 0;
    m_load       = 1'b0;
    m_flen       = '0;
  endtask

  // Expected outputs for the current cycle from model state and the applied halt/throttle.
  task automatic checkCycle();
    bit  busy_e, go;
    int  grant_e, last_e;
    busy_e  = m_load || (m_beats_left > 0);
    go      = !m_load && (m_beats_left > 0) && !(bus.halt || bus.throttle);
    grant_e = busy_e ? (1 << m_win) : 0;
    last_e  = (!m_load && m_beats_left == 1) ? ((m_len - 1) % BEAT_DW) : (BEAT_DW - 1);
    checkOutput("busy",       32'(bus.busy),       32'(busy_e));
    checkOutput("req_grant",  32'(bus.req_grant),  32'(grant_e));
    checkOutput("frag_start", 32'(bus.frag_start), 32'(m_load));
    checkOutput("frag_len",   32'(bus.frag_len),   32'(m_flen));
    checkOutput("beat_valid", 32'(bus.beat_valid), 32'(go));
    checkOutput("sop",        32'(bus.sop),        32'(go && m_beat_no == 0));
    checkOutput("eop",        32'(bus.eop),        32'(go && m_beats_left == 1));
    checkOutput("last_dw",    32'(bus.last_dw),    32'(last_e));
    if (bus.beat_valid === 1'b1) beat_count++;
    if (bus.beat_valid === 1'b1 && bus.eop === 1'b1) eop_count++;
    if (bus.frag_start === 1'b1) grant_log.push_back(bus.req_grant);
  endtask

  // Advance the model by one clock using the inputs the DUT sampled at this edge.
  task automatic modelUpdate();
    bit found;
    if (arst) begin
      modelReset();
    end else if (m_load) begin
      m_load       = 1'b0;
      m_beats_left = (m_len + BEAT_DW - 1) / BEAT_DW;
      m_beat_no    = 0;
    end else if (m_beats_left > 0) begin
      if (!(bus.halt || bus.throttle)) begin
        m_beat_no++;
        m_beats_left--;
        if (m_beats_left == 0) m_ptr = m_win;
      end
    end else if (|bus.req_valid) begin
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!found && bus.req_valid[(m_ptr + k) % NUM_REQ]) begin
          found = 1'b1;
          m_win = (m_ptr + k) % NUM_REQ;
        end
      end
      m_flen = bus.req_len[m_win*LEN_W +: LEN_W];
      m_len  = (m_flen == 0) ? MAX_DW : int'(m_flen);
      m_load = 1'b1;
    end
  endtask

  // Entered just after a rising edge; drives inputs, checks at the falling edge, steps the model.
  task automatic applyStimulus(input logic rst, input logic [NUM_REQ-1:0] v,
                               input logic [NUM_REQ*LEN_W-1:0] lens, input logic h, input logic t);
    arst          = rst;
    bus.req_valid = v;
    bus.req_len   = lens;
    bus.halt      = h;
    bus.throttle  = t;
    @(negedge clk);
    checkCycle();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  logic [NUM_REQ*LEN_W-1:0] rnd_lens;
  logic [NUM_REQ-1:0]       rnd_valid;
  int                       b0, e0, r;

  initial begin
    arst          = 1'b1;
    bus.req_valid = '0;
    bus.req_len   = '0;
    bus.halt      = 1'b0;
    bus.throttle  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // single source, 12 DW: two beats, second one ends at DW 3
    b0 = beat_count; e0 = eop_count;
    applyStimulus(1'b0, 3'b001, {10'd0, 10'd0, 10'd12}, 1'b0, 1'b0);
    idleCycles(5);
    checkOutput("t1_beats", 32'(beat_count - b0), 32'd2);
    checkOutput("t1_eops",  32'(eop_count - e0),  32'd1);

    // all sources, 8 DW each: rotation from source 0 after reset
    applyStimulus(1'b1, '0, '0, 1'b0, 1'b0);
    grant_log.delete();
    for (int i = 0; i < 13; i++) applyStimulus(1'b0, 3'b111, {10'd8, 10'd8, 10'd8}, 1'b0, 1'b0);
    idleCycles(3);
    checkOutput("t2_ntlp", 32'(grant_log.size() >= 4), 32'd1);
    if (grant_log.size() >= 4) begin
      checkOutput("t2_g0", 32'(grant_log[0]), 32'b001);
      checkOutput("t2_g1", 32'(grant_log[1]), 32'b010);
      checkOutput("t2_g2", 32'(grant_log[2]), 32'b100);
      checkOutput("t2_g3", 32'(grant_log[3]), 32'b001);
    end

    // length field 0 means 1024 DW
    b0 = beat_count; e0 = eop_count;
    applyStimulus(1'b0, 3'b001, {10'd0, 10'd0, 10'd0}, 1'b0, 1'b0);
    idleCycles(135);
    checkOutput("t3_beats", 32'(beat_count - b0), 32'd128);
    checkOutput("t3_eops",  32'(eop_count - e0),  32'd1);

    // 24 DW with throttle then halt stalls
    b0 = beat_count;
    applyStimulus(1'b0, 3'b001, {10'd0, 10'd0, 10'd24}, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b000, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b000, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b000, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'b000, '0, 1'b1, 1'b0);
    idleCycles(5);
    checkOutput("t4_beats", 32'(beat_count - b0), 32'd3);

    // reset on the second beat of a 5-beat TLP, source 1 pending
    applyStimulus(1'b0, 3'b001, {10'd0, 10'd0, 10'd40}, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b000, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b000, '0, 1'b0, 1'b0);
    e0 = eop_count;
    applyStimulus(1'b1, 3'b010, {10'd0, 10'd16, 10'd0}, 1'b0, 1'b0);
    grant_log.delete();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 3'b010, {10'd0, 10'd16, 10'd0}, 1'b0, 1'b0);
    checkOutput("t5_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : '0), 32'b010);
    idleCycles(4);

    // source drops valid and changes length mid-transfer
    b0 = beat_count;
    applyStimulus(1'b0, 3'b100, {10'd20, 10'd0, 10'd0}, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 3'b000, {10'd100, 10'd0, 10'd0}, 1'b0, 1'b0);
    checkOutput("t6_beats", 32'(beat_count - b0), 32'd3);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      for (int s = 0; s < NUM_REQ; s++) begin
        r = $urandom_range(0, 19);
        if (r == 0)      rnd_lens[s*LEN_W +: LEN_W] = '0;
        else if (r < 3)  rnd_lens[s*LEN_W +: LEN_W] = LEN_W'($urandom_range(100, 300));
        else             rnd_lens[s*LEN_W +: LEN_W] = LEN_W'($urandom_range(1, 24));
      end
      rnd_valid = ($urandom_range(0, 3) == 0) ? '0 : NUM_REQ'($urandom);
      applyStimulus($urandom_range(0, 299) == 0, rnd_valid, rnd_lens,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
